// File: rtl/vga_sync_receiver_if.sv
// Pin-level VGA link plus the receiver's reconstructed pixel stream.
// The timing source side is the master; the receiver is the slave.
interface vga_sync_receiver_if;
    logic       hsync;
    logic       vsync;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic       pix_valid;
    logic [9:0] rx_x;
    logic [8:0] rx_y;
    logic [7:0] rx_r;
    logic [7:0] rx_g;
    logic [7:0] rx_b;

    modport master (
        output hsync, vsync, VGA_R, VGA_G, VGA_B,
        input  locked, frame_start, sync_err, pix_valid,
        input  rx_x, rx_y, rx_r, rx_g, rx_b
    );

    modport slave (
        input  hsync, vsync, VGA_R, VGA_G, VGA_B,
        output locked, frame_start, sync_err, pix_valid,
        output rx_x, rx_y, rx_r, rx_g, rx_b
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// VGA receive front end: validates line/frame timing from hsync/vsync, locks after
// one clean frame and emits visible pixels with their coordinates and colour.
module vga_sync_receiver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic               CLK25,
    input  logic               RST_BTN,
    vga_sync_receiver_if.slave vga
);

    // state   | meaning
    // --------+------------------------------------------------------
    // IDLE    | after reset; waiting for the first vsync fall
    // MEASURE | timing one frame; any bad line spoils this attempt
    // LOCKED  | line and frame lengths match; pixels are emitted
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // v_cnt is 10 bits so that row counts up to V_TOTAL-1 are representable.
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_VIS_HI = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_VIS_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_VIS_HI = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [9:0] CNT_MAX  = 10'h3FF;

    logic        hs_s1_q, hs_s1_d;
    logic        vs_s1_q, vs_s1_d;
    logic        hs_s2_q, hs_s2_d;
    logic        vs_s2_q, vs_s2_d;
    logic [23:0] rgb_s1_q, rgb_s1_d;
    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    state_t      state_q, state_d;
    logic        bad_q, bad_d;
    logic        skip_q, skip_d;
    logic        locked_q, locked_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_err_q, sync_err_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  rx_x_q, rx_x_d;
    logic [8:0]  rx_y_q, rx_y_d;
    logic [23:0] rx_rgb_q, rx_rgb_d;

    logic hs_fall;
    logic vs_fall;
    logic line_err;
    logic frame_err;
    logic err_locked;
    logic fs_locked;
    logic visible;

    always_ff @(posedge CLK25 or negedge RST_BTN) begin
        if (!RST_BTN) begin
            hs_s1_q       <= 1'b1;
            vs_s1_q       <= 1'b1;
            hs_s2_q       <= 1'b1;
            vs_s2_q       <= 1'b1;
            rgb_s1_q      <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            state_q       <= ST_IDLE;
            bad_q         <= 1'b0;
            skip_q        <= 1'b1;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
            pix_valid_q   <= 1'b0;
            rx_x_q        <= '0;
            rx_y_q        <= '0;
            rx_rgb_q      <= '0;
        end else begin
            hs_s1_q       <= hs_s1_d;
            vs_s1_q       <= vs_s1_d;
            hs_s2_q       <= hs_s2_d;
            vs_s2_q       <= vs_s2_d;
            rgb_s1_q      <= rgb_s1_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            state_q       <= state_d;
            bad_q         <= bad_d;
            skip_q        <= skip_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
            pix_valid_q   <= pix_valid_d;
            rx_x_q        <= rx_x_d;
            rx_y_q        <= rx_y_d;
            rx_rgb_q      <= rx_rgb_d;
        end
    end

    // Front end: sync capture, edge detect, position counters and timing checks.
    always_comb begin
        hs_s1_d  = vga.hsync;
        vs_s1_d  = vga.vsync;
        rgb_s1_d = {vga.VGA_R, vga.VGA_G, vga.VGA_B};
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;

        hs_fall = hs_s2_q & ~hs_s1_q;
        vs_fall = vs_s2_q & ~vs_s1_q;

        if (hs_fall) begin
            h_cnt_d = '0;
        end else if (h_cnt_q == CNT_MAX) begin
            h_cnt_d = h_cnt_q;
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end

        v_cnt_d = v_cnt_q;
        if (vs_fall) begin
            v_cnt_d = '0;
        end else if (hs_fall && (v_cnt_q != CNT_MAX)) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end

        // The first line after leaving IDLE has an unknown start, so it is not judged.
        skip_d = (state_q == ST_IDLE) ? 1'b1 : (hs_fall ? 1'b0 : skip_q);

        line_err  = hs_fall && (state_q != ST_IDLE) && !skip_q && (h_cnt_q != H_LAST);
        frame_err = vs_fall && (v_cnt_q != V_LAST);
    end

    always_comb begin
        state_d    = state_q;
        bad_d      = bad_q;
        err_locked = 1'b0;
        fs_locked  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (vs_fall) begin
                    state_d = ST_MEASURE;
                    bad_d   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (line_err) begin
                    bad_d = 1'b1;
                end
                if (vs_fall) begin
                    if (!bad_q && !line_err && !frame_err) begin
                        state_d = ST_LOCKED;
                    end
                    bad_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (line_err || frame_err) begin
                    err_locked = 1'b1;
                    state_d    = ST_MEASURE;
                    bad_d      = 1'b0;
                end else if (vs_fall) begin
                    fs_locked = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                bad_d   = 1'b0;
            end
        endcase
    end

    // Output stage: coordinates and colour of the stage-1 sample, held while not visible.
    always_comb begin
        visible = (h_cnt_d >= H_VIS_LO) && (h_cnt_d <= H_VIS_HI) &&
                  (v_cnt_d >= V_VIS_LO) && (v_cnt_d <= V_VIS_HI);

        locked_d      = (state_d == ST_LOCKED);
        frame_start_d = fs_locked;
        sync_err_d    = err_locked;
        pix_valid_d   = (state_d == ST_LOCKED) && visible;

        rx_x_d   = rx_x_q;
        rx_y_d   = rx_y_q;
        rx_rgb_d = rx_rgb_q;
        if (pix_valid_d) begin
            rx_x_d   = h_cnt_d - H_VIS_LO;
            rx_y_d   = 9'(v_cnt_d - V_VIS_LO);
            rx_rgb_d = rgb_s1_q;
        end
    end

    assign vga.locked      = locked_q;
    assign vga.frame_start = frame_start_q;
    assign vga.sync_err    = sync_err_q;
    assign vga.pix_valid   = pix_valid_q;
    assign vga.rx_x        = rx_x_q;
    assign vga.rx_y        = rx_y_q;
    assign vga.rx_r        = rx_rgb_q[23:16];
    assign vga.rx_g        = rx_rgb_q[15:8];
    assign vga.rx_b        = rx_rgb_q[7:0];

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver on a shrunken raster: a frame generator drives the pins,
// a pin-level reference pushes expected outputs, compared two cycles later.
module tb_vga_sync_receiver;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int M_IDLE = 0;
    localparam int M_MEAS = 1;
    localparam int M_LOCK = 2;

    typedef struct {
        int          idx;
        logic [46:0] outs;
    } exp_t;

    logic CLK25;
    logic RST_BTN;

    vga_sync_receiver_if vga ();

    vga_sync_receiver #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) dut (
        .CLK25   (CLK25),
        .RST_BTN (RST_BTN),
        .vga     (vga)
    );

    initial CLK25 = 1'b0;
    always #5 CLK25 = ~CLK25;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   drv_idx = 0;

    // reference state, kept in terms of pin events
    logic       m_prev_hs, m_prev_vs, m_skip, m_bad;
    int         m_state, m_lines, m_last_hf;
    logic [9:0] m_x;
    logic [8:0] m_y;
    logic [7:0] m_r, m_g, m_b;

    int   first_vs_idx, lock_rise_idx;
    logic seen_vs, obs_lock_prev;
    int   cnt_pix, cnt_fs, cnt_err;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [46:0] obs();
        return {vga.locked, vga.frame_start, vga.sync_err, vga.pix_valid,
                vga.rx_x, vga.rx_y, vga.rx_r, vga.rx_g, vga.rx_b};
    endfunction

    task automatic model_reset();
        m_prev_hs     = 1'b1;
        m_prev_vs     = 1'b1;
        m_skip        = 1'b1;
        m_bad         = 1'b0;
        m_state       = M_IDLE;
        m_lines       = 0;
        m_last_hf     = drv_idx;
        m_x           = '0;
        m_y           = '0;
        m_r           = '0;
        m_g           = '0;
        m_b           = '0;
        seen_vs       = 1'b0;
        first_vs_idx  = -1;
        lock_rise_idx = -1;
        obs_lock_prev = 1'b0;
    endtask

    task automatic clr_cnt();
        cnt_pix = 0;
        cnt_fs  = 0;
        cnt_err = 0;
    endtask

    task automatic drive(input logic hs, input logic vs, input logic act, input int col, input int row);
        logic        hf, vf, lerr, ferr, e_err, e_fs, e_pix;
        logic [7:0]  r, g, b;
        logic [46:0] got;
        exp_t        e;
        hf = m_prev_hs & ~hs;
        vf = m_prev_vs & ~vs;
        if (vf && !seen_vs) begin
            first_vs_idx = drv_idx;
            seen_vs      = 1'b1;
        end
        lerr  = hf && (m_state != M_IDLE) && !m_skip && ((drv_idx - m_last_hf) != H_TOT);
        ferr  = vf && (m_state != M_IDLE) && (m_lines != V_TOT - 1);
        e_err = 1'b0;
        e_fs  = 1'b0;
        m_skip = (m_state == M_IDLE) ? 1'b1 : (hf ? 1'b0 : m_skip);
        case (m_state)
            M_IDLE: if (vf) begin m_state = M_MEAS; m_bad = 1'b0; end
            M_MEAS: begin
                if (vf) begin
                    if (!m_bad && !lerr && !ferr) m_state = M_LOCK;
                    m_bad = 1'b0;
                end else if (lerr) begin
                    m_bad = 1'b1;
                end
            end
            default: begin
                if (lerr || ferr) begin
                    e_err   = 1'b1;
                    m_state = M_MEAS;
                    m_bad   = 1'b0;
                end else if (vf) begin
                    e_fs = 1'b1;
                end
            end
        endcase
        if (vf) m_lines = 0;
        else if (hf) m_lines++;
        if (hf) m_last_hf = drv_idx;
        m_prev_hs = hs;
        m_prev_vs = vs;

        r = act ? 8'(col) : 8'h00;
        g = act ? 8'(row) : 8'h00;
        b = act ? 8'(col * 16 + row + 1) : 8'h00;
        e_pix = (m_state == M_LOCK) && act;
        if (e_pix) begin
            m_x = 10'(col);
            m_y = 9'(row);
            m_r = r;
            m_g = g;
            m_b = b;
        end
        e.idx  = drv_idx;
        e.outs = {(m_state == M_LOCK), e_fs, e_err, e_pix, m_x, m_y, m_r, m_g, m_b};

        vga.hsync = hs;
        vga.vsync = vs;
        vga.VGA_R = r;
        vga.VGA_G = g;
        vga.VGA_B = b;
        sb_q.push_back(e);
        drv_idx++;

        @(negedge CLK25);
        if (sb_q.size() == 2) begin
            e   = sb_q.pop_front();
            got = obs();
            chk_eq("outs", 64'(got), 64'(e.outs));
            if (got[46] && !obs_lock_prev && lock_rise_idx < 0) lock_rise_idx = e.idx;
            obs_lock_prev = got[46];
            cnt_pix += int'(got[43]);
            cnt_fs  += int'(got[45]);
            cnt_err += int'(got[44]);
        end
    endtask

    // Async reset in the middle of a cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        @(posedge CLK25);
        #2;
        RST_BTN = 1'b0;
        #1;
        chk_eq("rst_async", 64'(obs()), 64'd0);
        repeat (2) @(negedge CLK25);
        RST_BTN = 1'b1;
        sb_q.delete();
        model_reset();
    endtask

    task automatic gen_frame(input int n_lines, input int short_line, input int glitch_line, input int rst_line);
        int   len, col, row;
        logic hs, vs, act;
        for (int ln = 0; ln < n_lines; ln++) begin
            len = (ln == short_line) ? H_TOT - 1 : H_TOT;
            for (int h = 0; h < len; h++) begin
                if (ln == rst_line && h == H_SYNC + H_BP + 3) do_reset();
                hs = (h >= H_SYNC);
                if (ln == glitch_line && h == H_TOT / 2) hs = 1'b0;
                vs  = (ln >= V_SYNC);
                col = h - (H_SYNC + H_BP);
                row = ln - (V_SYNC + V_BP);
                act = (col >= 0) && (col < H_ACTIVE) && (row >= 0) && (row < V_ACTIVE);
                drive(hs, vs, act, col, row);
            end
        end
    endtask

    initial begin
        RST_BTN   = 1'b0;
        vga.hsync = 1'b1;
        vga.vsync = 1'b1;
        vga.VGA_R = '0;
        vga.VGA_G = '0;
        vga.VGA_B = '0;
        model_reset();
        clr_cnt();
        repeat (3) @(negedge CLK25);
        chk_eq("rst_state", 64'(obs()), 64'd0);
        RST_BTN = 1'b1;

        // nominal frames: lock after one clean frame, then steady output
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);
        chk_eq("lock_lat", 64'(lock_rise_idx - first_vs_idx), 64'(H_TOT * V_TOT));
        clr_cnt();
        gen_frame(V_TOT, -1, -1, -1);
        chk_eq("pix_cnt", 64'(cnt_pix), 64'(H_ACTIVE * V_ACTIVE));
        chk_eq("fs_cnt", 64'(cnt_fs), 64'd1);
        chk_eq("err_cnt", 64'(cnt_err), 64'd0);

        // one line a cycle short
        clr_cnt();
        gen_frame(V_TOT, 5, -1, -1);
        chk_eq("short_err", 64'(cnt_err), 64'd1);
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);

        // one frame a line long
        gen_frame(V_TOT + 1, -1, -1, -1);
        clr_cnt();
        gen_frame(V_TOT, -1, -1, -1);
        chk_eq("long_err", 64'(cnt_err), 64'd1);
        chk_eq("long_fs", 64'(cnt_fs), 64'd0);
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);

        // extra hsync fall mid-line
        clr_cnt();
        gen_frame(V_TOT, -1, 3, -1);
        chk_eq("glitch_err", 64'(cnt_err), 64'd1);
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);

        // reset mid-line while locked, then reacquire
        gen_frame(V_TOT, -1, -1, V_SYNC + V_BP + 2);
        gen_frame(V_TOT, -1, -1, -1);
        gen_frame(V_TOT, -1, -1, -1);
        chk_eq("relock_lat", 64'(lock_rise_idx - first_vs_idx), 64'(H_TOT * V_TOT));
        clr_cnt();
        gen_frame(V_TOT, -1, -1, -1);
        chk_eq("relock_pix", 64'(cnt_pix), 64'(H_ACTIVE * V_ACTIVE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
